hw_controller: RTL and testbench
================================

Name: hw_controller

Overview:
Multi-cycle hardwired control unit for the 4-register teaching CPU. It owns the program counter, drives the instruction ROM address and latches the returned word into an instruction register. It decodes the 14-bit instruction and sequences the register file and ALU datapath through FETCH/DECODE/EXEC/WB states, generating every datapath control strobe.
Instruction format: opcode[13:10], rs1[9:8], rs2[7:6], rd[5:4], imm[3:0]. Bits [15:14] of the ROM word are ignored.

Parameters:
PC_W, 4, program counter / ROM address width
IW, 14, instruction width latched into the instruction register
RET_W, 8, width of the retired-instruction counter

Ports:
iClk  in  1  clock; all state updates on the rising edge
iRst  in  1  synchronous, active-high reset
iRun  in  1  start request, sampled only in IDLE
iInstr  in  16  ROM data (combinational read of oPc)
iZero  in  1  ALU zero flag (rs1 - rs2 == 0), valid in EXEC
oPc  out  PC_W  ROM address / current PC
oRs1  out  2  register file read address A (IR[9:8])
oRs2  out  2  register file read address B (IR[7:6])
oRd  out  2  register file write address (IR[5:4])
oImm  out  4  zero-extended immediate (IR[3:0])
oAluOp  out  3  0 add, 1 sub, 2 and, 3 or, 4 xor
oAluSrcImm  out  1  ALU B operand = imm when 1, else rs2
oRegWe  out  1  register file write enable, one-cycle pulse
oHalt  out  1  high while in HALT
oIllegal  out  1  sticky; set on an undefined opcode
oRetired  out  RET_W  count of completed instructions, saturates at all-ones

Behaviour:
- Reset: state=IDLE, PC=0, IR=0, oRetired=0, oIllegal=0, oRegWe=0, oHalt=0.
- Reset mid-instruction aborts the instruction with no write.
- Outputs oRs1/oRs2/oRd/oImm/oAluOp/oAluSrcImm are decoded from IR, which is 0 after reset.
- Opcodes:
  - 0000 nop; 0001 add; 0010 sub; 0011 and; 0100 or; 0101 xor.
  - 0110 addi; 0111 andi; 1000 ori.
  - 1010 beq; 1011 bne; 1100 jmp; 1111 halt.
  - 1001, 1101 and 1110 are illegal.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: stays while iRun=0. Goes to FETCH on iRun=1.
- FETCH: oPc=PC. Latches IR <= iInstr[13:0] at the end of the cycle. Always goes to DECODE.
- DECODE: register file read. Decodes into:
  - halt -> HALT.
  - illegal -> set oIllegal, PC <= PC+1, retire, then FETCH.
  - all other opcodes -> EXEC.
- EXEC: ALU operating; oAluOp and oAluSrcImm are valid here and in WB.
  - ALU ops -> WB.
  - nop -> PC+1, retire, then FETCH.
  - beq taken if iZero=1; bne taken if iZero=0.
  - Taken branch or jmp: PC <= imm (absolute target). Not taken: PC <= PC+1. Then retire and go to FETCH.
- WB: oRegWe=1 for exactly this cycle, except when rd==0: r0 is hardwired zero and oRegWe stays 0. PC <= PC+1, retire, then FETCH.
- Latency:
  - ALU/immediate instructions: 4 cycles.
  - branch, jmp and nop: 3 cycles.
  - illegal: 2 cycles.
  - halt: 2 cycles to reach HALT.
- PC arithmetic is modulo 2^PC_W: PC=15 increments to 0.
- A branch to its own address loops forever; this is legal.
- HALT: oHalt=1. PC holds the halt instruction's address. Exited only by iRst; iRun is ignored.
- iRun is ignored outside IDLE; deasserting it does not pause execution.
- oRetired increments by 1 on each retire and holds at 2^RET_W-1.
- oRegWe is never asserted outside WB.

Test Plan:
- Reset sequencing: assert iRst for 2 cycles with iRun=1 -> oPc=0, oRegWe=0, oRetired=0. FETCH starts exactly 1 cycle after iRst falls.
- addi r1,r0,#5 at PC0 -> in WB (4th cycle after FETCH entry): oRd=1, oImm=5, oAluOp=0, oAluSrcImm=1, oRegWe=1 for 1 cycle; then oPc=1 and oRetired=1.
- sub r3,r1,r2 at PC2 -> oRs1=1, oRs2=2, oRd=3, oAluOp=1, oAluSrcImm=0, oRegWe pulse in WB. Also: add r0,r1,r2 -> oRegWe stays 0, PC still advances.
- bne r2,r3,#0 at PC3: with iZero=0 in EXEC -> next oPc=0, 3 cycles, no oRegWe. Rerun with iZero=1 -> next oPc=4.
- Wrap and halt: jmp #15 with 0x0000 (nop) at addr 15 -> oPc sequence 15 then 0. A halt word (opcode 1111) -> oHalt=1 two cycles after FETCH and stays set with iRun toggling; only iRst clears it.
- Illegal opcode 1101 at PC5 -> oIllegal=1 sticky, oPc=6 two cycles later, oRetired increments. With 255 instructions already retired, oRetired stays 255.

Source files
------------

// File: rtl/hw_controller.sv
// Multi-cycle hardwired control unit for the 4-register teaching CPU.
// Owns PC and IR, sequences FETCH/DECODE/EXEC/WB and drives every datapath strobe.
module hw_controller #(
  parameter int PC_W  = 4,
  parameter int IW    = 14,
  parameter int RET_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iRun,
  input  logic [15:0]      iInstr,
  input  logic             iZero,
  output logic [PC_W-1:0]  oPc,
  output logic [1:0]       oRs1,
  output logic [1:0]       oRs2,
  output logic [1:0]       oRd,
  output logic [3:0]       oImm,
  output logic [2:0]       oAluOp,
  output logic             oAluSrcImm,
  output logic             oRegWe,
  output logic             oHalt,
  output logic             oIllegal,
  output logic [RET_W-1:0] oRetired,
  output logic [2:0]       oState
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_ANDI = 4'h7;
  localparam logic [3:0] OP_ORI  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            r_state;
  state_t            w_next;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_next;
  logic [IW-1:0]     r_ir;
  logic [RET_W-1:0]  r_retired;
  logic              r_illegal;

  logic              w_ir_load;
  logic              w_retire;
  logic              w_set_illegal;
  logic              w_reg_we;

  logic [3:0]        w_op;
  logic              w_is_alu;
  logic              w_is_imm;
  logic              w_is_branch;
  logic              w_is_jmp;
  logic              w_is_halt;
  logic              w_is_illegal;
  logic              w_taken;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_target;
  logic [2:0]        w_alu_op;
  logic              w_unused;

  // ROM bits above the instruction width carry no meaning.
  assign w_unused = ^iInstr[15:IW];

  assign w_op      = r_ir[13:10];
  assign w_pc_inc  = r_pc + 1'b1;
  assign w_target  = PC_W'(r_ir[3:0]);

  always_comb begin
    w_is_alu     = 1'b0;
    w_is_imm     = 1'b0;
    w_is_branch  = 1'b0;
    w_is_jmp     = 1'b0;
    w_is_halt    = 1'b0;
    w_is_illegal = 1'b0;
    w_alu_op     = 3'd0;
    case (w_op)
      OP_NOP:  ;
      OP_ADD:  begin w_is_alu = 1'b1; w_alu_op = 3'd0; end
      OP_SUB:  begin w_is_alu = 1'b1; w_alu_op = 3'd1; end
      OP_AND:  begin w_is_alu = 1'b1; w_alu_op = 3'd2; end
      OP_OR:   begin w_is_alu = 1'b1; w_alu_op = 3'd3; end
      OP_XOR:  begin w_is_alu = 1'b1; w_alu_op = 3'd4; end
      OP_ADDI: begin w_is_alu = 1'b1; w_is_imm = 1'b1; w_alu_op = 3'd0; end
      OP_ANDI: begin w_is_alu = 1'b1; w_is_imm = 1'b1; w_alu_op = 3'd2; end
      OP_ORI:  begin w_is_alu = 1'b1; w_is_imm = 1'b1; w_alu_op = 3'd3; end
      // Branches subtract so the ALU zero flag reflects rs1 == rs2.
      OP_BEQ:  begin w_is_branch = 1'b1; w_alu_op = 3'd1; end
      OP_BNE:  begin w_is_branch = 1'b1; w_alu_op = 3'd1; end
      OP_JMP:  w_is_jmp  = 1'b1;
      OP_HALT: w_is_halt = 1'b1;
      default: w_is_illegal = 1'b1;
    endcase
  end

  assign w_taken = w_is_jmp ||
                   (w_is_branch && ((w_op == OP_BEQ) ? iZero : !iZero));

  always_comb begin
    w_next        = r_state;
    w_pc_next     = r_pc;
    w_ir_load     = 1'b0;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_reg_we      = 1'b0;
    case (r_state)
      // iRun is a level start request; it is only looked at here.
      S_IDLE: begin
        if (iRun) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_ir_load = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_halt) begin
          w_next = S_HALT;
        end else if (w_is_illegal) begin
          w_set_illegal = 1'b1;
          w_pc_next     = w_pc_inc;
          w_retire      = 1'b1;
          w_next        = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_alu) begin
          w_next = S_WB;
        end else begin
          w_pc_next = w_taken ? w_target : w_pc_inc;
          w_retire  = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_WB: begin
        // r0 is hardwired zero, so a write to it is suppressed.
        w_reg_we  = (r_ir[5:4] != 2'd0);
        w_pc_next = w_pc_inc;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      if (w_ir_load) r_ir <= iInstr[IW-1:0];
      if (w_retire && (r_retired != {RET_W{1'b1}})) r_retired <= r_retired + 1'b1;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  assign oPc        = r_pc;
  assign oRs1       = r_ir[9:8];
  assign oRs2       = r_ir[7:6];
  assign oRd        = r_ir[5:4];
  assign oImm       = r_ir[3:0];
  assign oAluOp     = w_alu_op;
  assign oAluSrcImm = w_is_imm;
  assign oRegWe     = w_reg_we;
  assign oHalt      = (r_state == S_HALT);
  assign oIllegal   = r_illegal;
  assign oRetired   = r_retired;
  assign oState     = r_state;

endmodule

// File: tb/tb_hw_controller.sv
// Self-checking bench for hw_controller: behavioural ROM, write-back scoreboard,
// and scenario tasks for sequencing, branching, wrap, halt, illegal and saturation.
module tb_hw_controller;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iRun;
  logic [15:0] iInstr;
  logic        iZero;
  logic [3:0]  oPc;
  logic [1:0]  oRs1, oRs2, oRd;
  logic [3:0]  oImm;
  logic [2:0]  oAluOp;
  logic        oAluSrcImm, oRegWe, oHalt, oIllegal;
  logic [7:0]  oRetired;
  logic [2:0]  oState;

  logic [15:0] rom [16];
  logic [13:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_we     = 0;

  hw_controller #(.PC_W(4), .IW(14), .RET_W(8)) dut (
    .iClk(iClk), .iRst(iRst), .iRun(iRun), .iInstr(iInstr), .iZero(iZero),
    .oPc(oPc), .oRs1(oRs1), .oRs2(oRs2), .oRd(oRd), .oImm(oImm),
    .oAluOp(oAluOp), .oAluSrcImm(oAluSrcImm), .oRegWe(oRegWe), .oHalt(oHalt),
    .oIllegal(oIllegal), .oRetired(oRetired), .oState(oState)
  );

  always #5 iClk = ~iClk;
  assign iInstr = rom[oPc];

  // Every register write is matched against the next expected write.
  always @(negedge iClk) begin
    logic [13:0] got, exp;
    if (oRegWe === 1'b1) begin
      n_we++;
      n_checks++;
      if (oState !== ST_WB) begin
        n_errors++;
        $display("FAIL we_outside_wb state=%0d required=%0d", oState, ST_WB);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write rd=%0d pc=%0d required no write", oRd, oPc);
      end else begin
        got = {oRd, oRs1, oRs2, oImm, oAluOp, oAluSrcImm};
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_errors++;
          $display("FAIL wb_fields got=%h required=%h", got, exp);
        end
      end
    end
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] d,
                                      input logic [3:0] imm);
    return {2'b00, op, a, b, d, imm};
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    tick();
    tick();
    iRst = 1'b0;
  endtask

  task automatic test_reset();
    fill_nop();
    iRun = 1'b1; iZero = 1'b0;
    do_reset();
    n_checks++; if (oPc !== 4'd0) begin n_errors++; $display("FAIL reset_pc got=%0d required=0", oPc); end
    n_checks++; if (oRegWe !== 1'b0) begin n_errors++; $display("FAIL reset_we got=%b required=0", oRegWe); end
    n_checks++; if (oRetired !== 8'd0) begin n_errors++; $display("FAIL reset_retired got=%0d required=0", oRetired); end
    n_checks++; if ({oHalt, oIllegal} !== 2'b00) begin n_errors++; $display("FAIL reset_flags got=%b required=00", {oHalt, oIllegal}); end
    n_checks++; if (oState !== ST_IDLE) begin n_errors++; $display("FAIL reset_state got=%0d required=%0d", oState, ST_IDLE); end
    n_checks++; if ({oRd, oRs1, oRs2, oImm, oAluOp, oAluSrcImm} !== 14'd0) begin
      n_errors++; $display("FAIL reset_decode got=%h required=0", {oRd, oRs1, oRs2, oImm, oAluOp, oAluSrcImm});
    end
    tick();
    n_checks++; if (oState !== ST_FETCH) begin n_errors++; $display("FAIL fetch_after_reset got=%0d required=%0d", oState, ST_FETCH); end
  endtask

  task automatic test_alu_ops();
    int cyc;
    int we0;
    fill_nop();
    rom[0] = enc(4'h6, 2'd0, 2'd0, 2'd1, 4'd5) | 16'hC000;
    rom[1] = enc(4'h1, 2'd1, 2'd2, 2'd0, 4'd0);
    rom[2] = enc(4'h2, 2'd1, 2'd2, 2'd3, 4'd0);
    rom[3] = enc(4'hB, 2'd2, 2'd3, 2'd0, 4'd0);
    rom[4] = enc(4'hF, 2'd0, 2'd0, 2'd0, 4'd0);
    iZero = 1'b0; iRun = 1'b0;
    do_reset();
    iRun = 1'b1;
    tick();
    iRun = 1'b0;
    exp_q.push_back({2'd1, 2'd0, 2'd0, 4'd5, 3'd0, 1'b1});
    cyc = 1;
    while (oRegWe !== 1'b1 && cyc < 8) begin tick(); cyc++; end
    n_checks++; if (cyc != 4) begin n_errors++; $display("FAIL addi_wb_cycle got=%0d required=4", cyc); end
    tick();
    n_checks++; if (oRegWe !== 1'b0) begin n_errors++; $display("FAIL addi_we_pulse got=%b required=0", oRegWe); end
    n_checks++; if ({oPc, oRetired} !== {4'd1, 8'd1}) begin n_errors++; $display("FAIL addi_next pc=%0d ret=%0d required pc=1 ret=1", oPc, oRetired); end
    we0 = n_we;
    repeat (4) tick();
    n_checks++; if (n_we != we0) begin n_errors++; $display("FAIL add_r0_no_write writes=%0d required=%0d", n_we, we0); end
    n_checks++; if ({oPc, oRetired} !== {4'd2, 8'd2}) begin n_errors++; $display("FAIL add_r0_next pc=%0d ret=%0d required pc=2 ret=2", oPc, oRetired); end
    exp_q.push_back({2'd3, 2'd1, 2'd2, 4'd0, 3'd1, 1'b0});
    repeat (3) tick();
    n_checks++; if (oRegWe !== 1'b1) begin n_errors++; $display("FAIL sub_we got=%b required=1", oRegWe); end
    tick();
    n_checks++; if (oPc !== 4'd3) begin n_errors++; $display("FAIL sub_next_pc got=%0d required=3", oPc); end
    we0 = n_we;
    repeat (3) tick();
    n_checks++; if ({oState, oPc} !== {ST_FETCH, 4'd0}) begin n_errors++; $display("FAIL bne_taken state=%0d pc=%0d required state=1 pc=0", oState, oPc); end
    n_checks++; if (oRetired !== 8'd4 || n_we != we0) begin n_errors++; $display("FAIL bne_taken_side ret=%0d writes=%0d required ret=4 writes=%0d", oRetired, n_we, we0); end
    iZero = 1'b1;
    exp_q.push_back({2'd1, 2'd0, 2'd0, 4'd5, 3'd0, 1'b1});
    exp_q.push_back({2'd3, 2'd1, 2'd2, 4'd0, 3'd1, 1'b0});
    repeat (12) tick();
    n_checks++; if ({oState, oPc} !== {ST_FETCH, 4'd3}) begin n_errors++; $display("FAIL rerun_at_bne state=%0d pc=%0d required state=1 pc=3", oState, oPc); end
    repeat (3) tick();
    n_checks++; if ({oState, oPc, oRetired} !== {ST_FETCH, 4'd4, 8'd8}) begin
      n_errors++; $display("FAIL bne_not_taken state=%0d pc=%0d ret=%0d required state=1 pc=4 ret=8", oState, oPc, oRetired);
    end
    repeat (2) tick();
    n_checks++; if (oHalt !== 1'b1) begin n_errors++; $display("FAIL alu_prog_halt got=%b required=1", oHalt); end
  endtask

  task automatic test_self_loop();
    fill_nop();
    rom[0] = enc(4'hA, 2'd0, 2'd0, 2'd0, 4'd0);
    iZero = 1'b1;
    do_reset();
    iRun = 1'b1;
    tick();
    iRun = 1'b0;
    repeat (9) tick();
    n_checks++; if ({oState, oPc, oRetired} !== {ST_FETCH, 4'd0, 8'd3}) begin
      n_errors++; $display("FAIL self_loop state=%0d pc=%0d ret=%0d required state=1 pc=0 ret=3", oState, oPc, oRetired);
    end
  endtask

  task automatic test_wrap_halt();
    fill_nop();
    rom[0] = enc(4'hC, 2'd0, 2'd0, 2'd0, 4'd15);
    iZero = 1'b0;
    do_reset();
    iRun = 1'b1;
    tick();
    repeat (3) tick();
    n_checks++; if ({oState, oPc} !== {ST_FETCH, 4'd15}) begin n_errors++; $display("FAIL jmp_15 state=%0d pc=%0d required state=1 pc=15", oState, oPc); end
    rom[0] = enc(4'hF, 2'd0, 2'd0, 2'd0, 4'd0);
    repeat (3) tick();
    n_checks++; if ({oState, oPc, oRetired} !== {ST_FETCH, 4'd0, 8'd2}) begin
      n_errors++; $display("FAIL pc_wrap state=%0d pc=%0d ret=%0d required state=1 pc=0 ret=2", oState, oPc, oRetired);
    end
    tick();
    n_checks++; if (oHalt !== 1'b0) begin n_errors++; $display("FAIL halt_early got=%b required=0", oHalt); end
    tick();
    n_checks++; if ({oHalt, oPc} !== {1'b1, 4'd0}) begin n_errors++; $display("FAIL halt_entry halt=%b pc=%0d required halt=1 pc=0", oHalt, oPc); end
    for (int i = 0; i < 6; i++) begin
      iRun = 1'($urandom_range(0, 1));
      tick();
      n_checks++; if ({oHalt, oState, oPc} !== {1'b1, ST_HALT, 4'd0}) begin
        n_errors++; $display("FAIL halt_hold halt=%b state=%0d pc=%0d required halt=1 state=5 pc=0", oHalt, oState, oPc);
      end
    end
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    n_checks++; if ({oHalt, oState} !== {1'b0, ST_IDLE}) begin n_errors++; $display("FAIL halt_reset halt=%b state=%0d required halt=0 state=0", oHalt, oState); end
  endtask

  task automatic test_illegal();
    fill_nop();
    rom[0] = enc(4'hC, 2'd0, 2'd0, 2'd0, 4'd5);
    rom[5] = enc(4'hD, 2'd0, 2'd0, 2'd0, 4'd0);
    rom[6] = enc(4'hE, 2'd0, 2'd0, 2'd0, 4'd0);
    rom[7] = enc(4'hF, 2'd0, 2'd0, 2'd0, 4'd0);
    iRun = 1'b0;
    do_reset();
    iRun = 1'b1;
    tick();
    repeat (3) tick();
    n_checks++; if ({oPc, oIllegal} !== {4'd5, 1'b0}) begin n_errors++; $display("FAIL illegal_pre pc=%0d ill=%b required pc=5 ill=0", oPc, oIllegal); end
    repeat (2) tick();
    n_checks++; if ({oState, oPc, oIllegal, oRetired} !== {ST_FETCH, 4'd6, 1'b1, 8'd2}) begin
      n_errors++; $display("FAIL illegal_d state=%0d pc=%0d ill=%b ret=%0d required state=1 pc=6 ill=1 ret=2", oState, oPc, oIllegal, oRetired);
    end
    repeat (2) tick();
    n_checks++; if ({oPc, oRetired} !== {4'd7, 8'd3}) begin n_errors++; $display("FAIL illegal_e pc=%0d ret=%0d required pc=7 ret=3", oPc, oRetired); end
    repeat (2) tick();
    n_checks++; if ({oHalt, oIllegal} !== 2'b11) begin n_errors++; $display("FAIL illegal_sticky got=%b required=11", {oHalt, oIllegal}); end
  endtask

  task automatic test_saturate();
    int cyc;
    fill_nop();
    do_reset();
    iRun = 1'b1;
    tick();
    iRun = 1'b0;
    cyc = 0;
    while (oRetired !== 8'd255 && cyc < 1000) begin tick(); cyc++; end
    n_checks++; if (cyc != 765) begin n_errors++; $display("FAIL retire_count cycles=%0d required=765", cyc); end
    rom[5] = enc(4'h9, 2'd0, 2'd0, 2'd0, 4'd0);
    cyc = 0;
    while (!(oState === ST_FETCH && oPc === 4'd6) && cyc < 100) begin tick(); cyc++; end
    n_checks++; if (cyc >= 100) begin n_errors++; $display("FAIL sat_timeout cycles=%0d required<100", cyc); end
    n_checks++; if ({oIllegal, oRetired} !== {1'b1, 8'd255}) begin
      n_errors++; $display("FAIL retire_saturate ill=%b ret=%0d required ill=1 ret=255", oIllegal, oRetired);
    end
  endtask

  task automatic test_reset_abort();
    fill_nop();
    rom[0] = enc(4'h6, 2'd0, 2'd0, 2'd2, 4'd9);
    do_reset();
    iRun = 1'b1;
    repeat (3) tick();
    n_checks++; if (oState !== ST_EXEC) begin n_errors++; $display("FAIL abort_setup state=%0d required=%0d", oState, ST_EXEC); end
    iRst = 1'b1;
    iRun = 1'b0;
    tick();
    iRst = 1'b0;
    repeat (2) tick();
    n_checks++; if ({oState, oPc, oRetired, oRegWe} !== {ST_IDLE, 4'd0, 8'd0, 1'b0}) begin
      n_errors++; $display("FAIL reset_abort state=%0d pc=%0d ret=%0d we=%b required state=0 pc=0 ret=0 we=0", oState, oPc, oRetired, oRegWe);
    end
  endtask

  initial begin
    iRst = 1'b1; iRun = 1'b0; iZero = 1'b0;
    fill_nop();
    test_reset();
    test_alu_ops();
    test_self_loop();
    test_wrap_halt();
    test_illegal();
    test_saturate();
    test_reset_abort();
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
